// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-side types and constants.
//   INSTR_W     - instruction word width
//   NOP_DEFAULT - default value presented when no instruction has been fetched
//   fetch_state_t - fetch FSM encoding (RUN / FAULT)
package cpu_pkg;
    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_DEFAULT = 32'h0000_0000;
    typedef enum logic {RUN = 1'b0, FAULT = 1'b1} fetch_state_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry holding register for an instruction word and its PC.
//   clk, rst (async, active-low)
//   load    - capture data_in/pc_in and mark valid (wins over drain)
//   drain   - clear valid after the entry has been consumed
//   data_in, pc_in - word and address to hold
//   valid, data, pc - held entry
module fetch_skid_buf
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               drain,
    input  logic [INSTR_W-1:0] data_in,
    input  logic [31:0]        pc_in,
    output logic               valid,
    output logic [INSTR_W-1:0] data,
    output logic [31:0]        pc
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            data  <= '0;
            pc    <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= data_in;
            pc    <= pc_in;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/prog_fetch_unit.sv
// prog_fetch_unit: program-memory fetch initiator with PC, branch, stall skid and sticky fault.
//   clk, rst (async, active-low)
//   stall, branch_en, branch_target, fault_clr - pipeline control
//   ADDR_Prog - fetch address (always the PC); CS_P - decoder accept for ADDR_Prog
//   instr_in  - ROM data, one cycle after an accepted address
//   instr_out, instr_pc, instr_valid - instruction handed to decode
//   fault, fault_addr - sticky fetch fault and the rejected address
module prog_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0]        RESET_PC = 32'h0000_4000,
    parameter logic [INSTR_W-1:0] NOP_WORD = NOP_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               branch_en,
    input  logic [31:0]        branch_target,
    input  logic               fault_clr,
    output logic [31:0]        ADDR_Prog,
    input  logic               CS_P,
    input  logic [INSTR_W-1:0] instr_in,
    output logic [INSTR_W-1:0] instr_out,
    output logic [31:0]        instr_pc,
    output logic               instr_valid,
    output logic               fault,
    output logic [31:0]        fault_addr
);
    fetch_state_t state, state_d;
    logic [31:0] pc, pend_pc;
    logic pending, accept, raise, clear, hold;
    logic skid_valid, deliver_skid, deliver_mem;
    logic [INSTR_W-1:0] skid_data;
    logic [31:0] skid_pc;
    logic unused_bits;
    assign unused_bits = ^branch_target[1:0];
    assign ADDR_Prog = pc;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RUN;
        else      state <= state_d;
    end
    // Stall only freezes RUN; in FAULT a pending read still drains to the outputs.
    always_comb begin
        state_d      = state;
        accept       = 1'b0;
        raise        = 1'b0;
        clear        = 1'b0;
        hold         = 1'b0;
        if (state == FAULT) begin
            clear   = fault_clr;
            state_d = fault_clr ? RUN : FAULT;
        end else if (stall) begin
            hold = 1'b1;
        end else begin
            accept  = CS_P;
            raise   = !CS_P;
            state_d = CS_P ? RUN : FAULT;
        end
        deliver_skid = !hold && skid_valid;
        deliver_mem  = !hold && !skid_valid && pending;
    end
    fetch_skid_buf u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (hold && pending),
        .drain   (deliver_skid),
        .data_in (instr_in),
        .pc_in   (pend_pc),
        .valid   (skid_valid),
        .data    (skid_data),
        .pc      (skid_pc)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC;
            pending     <= 1'b0;
            pend_pc     <= '0;
            instr_out   <= NOP_WORD;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
            fault_addr  <= '0;
        end else begin
            pending     <= accept;
            instr_valid <= deliver_skid || deliver_mem;
            if (clear) pc <= RESET_PC;
            else if (accept) pc <= branch_en ? {branch_target[31:2], 2'b00} : pc + 32'd4;
            if (accept) pend_pc <= pc;
            if (raise) begin
                fault      <= 1'b1;
                fault_addr <= pc;
            end else if (clear) begin
                fault <= 1'b0;
            end
            if (deliver_skid) begin
                instr_out <= skid_data;
                instr_pc  <= skid_pc;
            end else if (deliver_mem) begin
                instr_out <= instr_in;
                instr_pc  <= pend_pc;
            end
        end
    end
endmodule

// File: tb/tb_prog_fetch_unit.sv
// tb_prog_fetch_unit: directed self-checking bench for prog_fetch_unit.
module tb_prog_fetch_unit;
    localparam logic [31:0] K = 32'hA5A5_0000;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        branch_en = 1'b0;
    logic [31:0] branch_target = '0;
    logic        fault_clr = 1'b0;
    logic [31:0] addr_prog;
    logic        cs_p;
    logic [31:0] instr_in = '0;
    logic [31:0] instr_out, instr_pc, fault_addr;
    logic        instr_valid, fault;
    int checks = 0;
    int failures = 0;

    prog_fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_en(branch_en),
        .branch_target(branch_target), .fault_clr(fault_clr),
        .ADDR_Prog(addr_prog), .CS_P(cs_p), .instr_in(instr_in),
        .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .fault(fault), .fault_addr(fault_addr)
    );

    always #5 clk = ~clk;
    assign cs_p = (addr_prog >= 32'h4000) && (addr_prog <= 32'h47FF);
    always @(posedge clk) instr_in <= addr_prog ^ K;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_out(input string tag, input logic [31:0] a, input logic [31:0] pc);
        check({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
        check({tag, "_pc"}, instr_pc, pc);
        check({tag, "_word"}, instr_out, pc ^ K);
        check({tag, "_addr"}, addr_prog, a);
    endtask

    initial begin
        // reset values
        repeat (2) @(negedge clk);
        check("rst_addr", addr_prog, 32'h4000);
        check("rst_out", instr_out, 32'h0);
        check("rst_ipc", instr_pc, 32'h0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_fault", {31'b0, fault}, 32'd0);
        check("rst_faddr", fault_addr, 32'h0);
        rst = 1'b1;
        // free run
        tick();
        check("run1_addr", addr_prog, 32'h4004);
        check("run1_valid", {31'b0, instr_valid}, 32'd0);
        tick();
        check_out("run2", 32'h4008, 32'h4000);
        // branch at 4008 to 4603 -> 4600
        branch_en = 1'b1;
        branch_target = 32'h4603;
        tick();
        branch_en = 1'b0;
        check_out("br1", 32'h4600, 32'h4004);
        tick();
        check_out("br2", 32'h4604, 32'h4008);
        tick();
        check_out("br3", 32'h4608, 32'h4600);
        // branch to 4800 -> fault on next edge
        branch_en = 1'b1;
        branch_target = 32'h4800;
        tick();
        branch_en = 1'b0;
        check_out("bf1", 32'h4800, 32'h4604);
        check("bf1_fault", {31'b0, fault}, 32'd0);
        tick();
        check_out("bf2", 32'h4800, 32'h4608);
        check("bf2_fault", {31'b0, fault}, 32'd1);
        check("bf2_faddr", fault_addr, 32'h4800);
        stall = 1'b1;
        tick();
        stall = 1'b0;
        check("flt_addr", addr_prog, 32'h4800);
        check("flt_valid", {31'b0, instr_valid}, 32'd0);
        check("flt_fault", {31'b0, fault}, 32'd1);
        fault_clr = 1'b1;
        tick();
        check("clr_addr", addr_prog, 32'h4000);
        check("clr_fault", {31'b0, fault}, 32'd0);
        check("clr_faddr", fault_addr, 32'h4800);
        tick();
        fault_clr = 1'b0;
        check("clr_run_addr", addr_prog, 32'h4004);
        check("clr_run_fault", {31'b0, fault}, 32'd0);
        tick();
        check_out("rs1", 32'h4008, 32'h4000);
        // three-cycle stall after 4004 accepted
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stl_addr", addr_prog, 32'h4008);
            check("stl_valid", {31'b0, instr_valid}, 32'd0);
            check("stl_ipc", instr_pc, 32'h4000);
        end
        stall = 1'b0;
        tick();
        check_out("rel1", 32'h400C, 32'h4004);
        tick();
        check_out("rel2", 32'h4010, 32'h4008);
        // stall with skid full, then async reset mid-cycle
        stall = 1'b1;
        tick();
        check("sk_valid", {31'b0, instr_valid}, 32'd0);
        check("sk_ipc", instr_pc, 32'h4008);
        #2 rst = 1'b0;
        #1;
        check("ar_out", instr_out, 32'h0);
        check("ar_ipc", instr_pc, 32'h0);
        check("ar_valid", {31'b0, instr_valid}, 32'd0);
        check("ar_addr", addr_prog, 32'h4000);
        @(negedge clk);
        rst = 1'b1;
        stall = 1'b0;
        tick();
        check("ar1_addr", addr_prog, 32'h4004);
        check("ar1_valid", {31'b0, instr_valid}, 32'd0);
        tick();
        check_out("ar2", 32'h4008, 32'h4000);
        // branch to 14F0 while stalled
        stall = 1'b1;
        branch_en = 1'b1;
        branch_target = 32'h14F0;
        tick();
        tick();
        check("bs_addr", addr_prog, 32'h4008);
        check("bs_fault", {31'b0, fault}, 32'd0);
        stall = 1'b0;
        tick();
        check_out("bs1", 32'h14F0, 32'h4004);
        check("bs1_fault", {31'b0, fault}, 32'd0);
        tick();
        branch_en = 1'b0;
        check_out("bs2", 32'h14F0, 32'h4008);
        check("bs2_fault", {31'b0, fault}, 32'd1);
        check("bs2_faddr", fault_addr, 32'h14F0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
